// File: rtl/perceptron_pkg.sv
// perceptron_pkg
//   Shared definitions for the perceptron training datapath.
//   - DATA_W_DEF / W_W_DEF : default sample and weight widths
//   - T_POS / T_NEG        : one-bit encoding of the +1 / -1 target values
//   - sign_of(net)         : classification rule, net >= 0 maps to +1
//   - sat_add(a, delta, w) : a + delta clamped to a w-bit signed range
package perceptron_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int W_W_DEF    = 16;

  localparam logic T_POS = 1'b1;
  localparam logic T_NEG = 1'b0;

  // Callers sign-extend their net value to 64 bits before calling.
  function automatic logic sign_of(input logic signed [63:0] net);
    return (net >= 64'sd0) ? T_POS : T_NEG;
  endfunction

  // Works for any result width w up to 32; the sum is formed one bit wider
  // than the operands so it can never wrap before the clamp.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] delta,
                                                 input int                 w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(delta);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/perceptron_sample_mem.sv
// perceptron_sample_mem
//   Training-sample register file: N_SAMPLES entries of {x1, x2, t}.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset (clears all entries)
//     we                : write strobe (already qualified by the controller's ready)
//     wr_addr           : write index; indices >= N_SAMPLES are dropped
//     wr_x1, wr_x2, wr_t: entry to store
//     rd_addr           : asynchronous read index
//     rd_x1, rd_x2, rd_t: entry at rd_addr
module perceptron_sample_mem
  import perceptron_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = $clog2(N_SAMPLES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [CNT_W-1:0]         wr_addr,
  input  logic signed [DATA_W-1:0] wr_x1,
  input  logic signed [DATA_W-1:0] wr_x2,
  input  logic                     wr_t,
  input  logic [CNT_W-1:0]         rd_addr,
  output logic signed [DATA_W-1:0] rd_x1,
  output logic signed [DATA_W-1:0] rd_x2,
  output logic                     rd_t
);

  localparam int               ENTRY_W = 2 * DATA_W + 1;
  localparam logic [CNT_W:0]   DEPTH   = (CNT_W + 1)'(N_SAMPLES);

  logic [ENTRY_W-1:0] mem [N_SAMPLES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        mem[i] <= '0;
      end
    end else if (we && ({1'b0, wr_addr} < DEPTH)) begin
      mem[wr_addr] <= {wr_x1, wr_x2, wr_t};
    end
  end

  assign {rd_x1, rd_x2, rd_t} = mem[rd_addr];

endmodule

// File: rtl/perceptron_datapath.sv
// perceptron_datapath
//   Datapath half of the perceptron trainer. Holds the sample memory, the
//   sample counter, weights w1/w2/b, the per-epoch update flag, an epoch
//   counter and the test-classification result.
//   Ports:
//     clk, rst                    : clock, asynchronous active-low reset
//     ready                       : controller idle; sample writes only land while high
//     initCounter .. enableTest   : controller strobes
//     alpha                       : unsigned learning rate
//     wr_en/wr_addr/wr_x1/wr_x2/wr_t : sample write port
//     x1_test, x2_test            : inputs to classify on enableTest
//     cout                        : counter at last sample (combinational)
//     flag                        : an update happened this epoch
//     update                      : current sample misclassified (combinational)
//     w1, w2, b                   : current weights
//     epochs                      : epochs run since the last initW1
//     y_test, y_valid             : classification result and its refresh pulse
//   y_valid is a one-cycle pulse on the cycle after enableTest; there is no
//   back-pressure, a consumer must take y_test then or read the held value later.
module perceptron_datapath
  import perceptron_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = $clog2(N_SAMPLES),
  parameter int W_INIT    = 0,
  parameter int EPOCH_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic                     initCounter,
  input  logic                     initW1,
  input  logic                     initW2,
  input  logic                     initB,
  input  logic                     initFlag,
  input  logic                     setFlag,
  input  logic                     ldW1,
  input  logic                     ldW2,
  input  logic                     ldB,
  input  logic                     enableCount,
  input  logic                     enableTest,
  input  logic [7:0]               alpha,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         wr_addr,
  input  logic signed [DATA_W-1:0] wr_x1,
  input  logic signed [DATA_W-1:0] wr_x2,
  input  logic                     wr_t,
  input  logic signed [DATA_W-1:0] x1_test,
  input  logic signed [DATA_W-1:0] x2_test,
  output logic                     cout,
  output logic                     flag,
  output logic                     update,
  output logic signed [W_W-1:0]    w1,
  output logic signed [W_W-1:0]    w2,
  output logic signed [W_W-1:0]    b,
  output logic [EPOCH_W-1:0]       epochs,
  output logic                     y_test,
  output logic                     y_valid
);

  // Two products plus bias need two guard bits above W_W+DATA_W.
  localparam int NET_W = W_W + DATA_W + 2;
  // alpha (8 bits unsigned) times a DATA_W signed sample, plus a sign bit.
  localparam int DELTA_W = DATA_W + 9;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(N_SAMPLES - 1);
  localparam logic signed [W_W-1:0] W_INIT_V  = W_W'(W_INIT);

  logic [CNT_W-1:0]         cnt;
  logic signed [DATA_W-1:0] mx1;
  logic signed [DATA_W-1:0] mx2;
  logic                     mt;

  logic signed [NET_W-1:0]   net;
  logic signed [NET_W-1:0]   net_test;
  logic signed [DELTA_W-1:0] alpha_s;
  logic signed [DELTA_W-1:0] d1;
  logic signed [DELTA_W-1:0] d2;
  logic signed [DELTA_W-1:0] db;

  perceptron_sample_mem #(
    .DATA_W    (DATA_W),
    .N_SAMPLES (N_SAMPLES),
    .CNT_W     (CNT_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en && ready),
    .wr_addr (wr_addr),
    .wr_x1   (wr_x1),
    .wr_x2   (wr_x2),
    .wr_t    (wr_t),
    .rd_addr (cnt),
    .rd_x1   (mx1),
    .rd_x2   (mx2),
    .rd_t    (mt)
  );

  // Classification of the current sample and of the test inputs.
  always_comb begin
    net = NET_W'(w1) * NET_W'(mx1) + NET_W'(w2) * NET_W'(mx2) + NET_W'(b);
    net_test = NET_W'(w1) * NET_W'(x1_test) + NET_W'(w2) * NET_W'(x2_test) + NET_W'(b);
    update = (sign_of(64'(net)) != mt);
  end

  // Learning steps alpha*t*x and alpha*t; t selects the sign.
  always_comb begin
    alpha_s = $signed({{(DELTA_W - 8){1'b0}}, alpha});
    d1 = alpha_s * DELTA_W'(mx1);
    d2 = alpha_s * DELTA_W'(mx2);
    db = alpha_s;
    if (mt == T_NEG) begin
      d1 = -d1;
      d2 = -d2;
      db = -db;
    end
  end

  assign cout = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (initCounter) begin
      cnt <= '0;
    end else if (enableCount) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Init has priority over load on each weight register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w1 <= '0;
      w2 <= '0;
      b  <= '0;
    end else begin
      if (initW1) begin
        w1 <= W_INIT_V;
      end else if (ldW1) begin
        w1 <= W_W'(sat_add(32'(w1), 32'(d1), W_W));
      end
      if (initW2) begin
        w2 <= W_INIT_V;
      end else if (ldW2) begin
        w2 <= W_W'(sat_add(32'(w2), 32'(d2), W_W));
      end
      if (initB) begin
        b <= W_INIT_V;
      end else if (ldB) begin
        b <= W_W'(sat_add(32'(b), 32'(db), W_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag <= 1'b0;
    end else if (initFlag) begin
      flag <= 1'b0;
    end else if (setFlag) begin
      flag <= 1'b1;
    end
  end

  // The controller pulses initFlag once at the start of every epoch, so
  // counting those pulses counts epochs. Saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epochs <= '0;
    end else if (initW1) begin
      epochs <= '0;
    end else if (initFlag && (epochs != '1)) begin
      epochs <= epochs + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_test  <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= enableTest;
      if (enableTest) begin
        y_test <= sign_of(64'(net_test));
      end
    end
  end

endmodule

// File: tb/tb_perceptron_datapath.sv
// tb_perceptron_datapath
//   Directed and randomized checks of perceptron_datapath against an
//   integer-arithmetic model of the perceptron learning rules.
module tb_perceptron_datapath;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic              initCounter, initW1, initW2, initB, initFlag, setFlag;
  logic              ldW1, ldW2, ldB, enableCount, enableTest;
  logic [7:0]        alpha;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic signed [7:0] wr_x1, wr_x2;
  logic              wr_t;
  logic signed [7:0] x1_test, x2_test;
  logic              cout, flag, update, y_test, y_valid;
  logic signed [15:0] w1, w2, b;
  logic [7:0]        epochs;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int mw1, mw2, mb, mcnt, mep;
  bit mflag;
  int mx1[8];
  int mx2[8];
  bit mt[8];

  perceptron_datapath dut (
    .clk(clk), .rst(rst), .ready(ready),
    .initCounter(initCounter), .initW1(initW1), .initW2(initW2), .initB(initB),
    .initFlag(initFlag), .setFlag(setFlag), .ldW1(ldW1), .ldW2(ldW2), .ldB(ldB),
    .enableCount(enableCount), .enableTest(enableTest), .alpha(alpha),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t),
    .x1_test(x1_test), .x2_test(x2_test),
    .cout(cout), .flag(flag), .update(update), .w1(w1), .w2(w2), .b(b),
    .epochs(epochs), .y_test(y_test), .y_valid(y_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int tsign(input bit t);
    return t ? 1 : -1;
  endfunction

  function automatic bit model_classify(input int x1, input int x2);
    return (mw1 * x1 + mw2 * x2 + mb) >= 0;
  endfunction

  function automatic bit model_update();
    return model_classify(mx1[mcnt], mx2[mcnt]) != mt[mcnt];
  endfunction

  task automatic model_reset();
    mw1 = 0; mw2 = 0; mb = 0; mcnt = 0; mep = 0; mflag = 0;
    for (int i = 0; i < 8; i++) begin
      mx1[i] = 0; mx2[i] = 0; mt[i] = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    initCounter = 0; initW1 = 0; initW2 = 0; initB = 0; initFlag = 0;
    setFlag = 0; ldW1 = 0; ldW2 = 0; ldB = 0; enableCount = 0; enableTest = 0;
    wr_en = 0;
  endtask

  task automatic write_sample(input int a, input int x1, input int x2, input bit t);
    wr_en = 1; wr_addr = 3'(a); wr_x1 = 8'(x1); wr_x2 = 8'(x2); wr_t = t;
    tick();
    wr_en = 0;
    if (ready) begin
      mx1[a] = x1; mx2[a] = x2; mt[a] = t;
    end
  endtask

  task automatic do_init_counter();
    initCounter = 1; tick(); initCounter = 0;
    mcnt = 0;
  endtask

  task automatic do_count();
    enableCount = 1; tick(); enableCount = 0;
    mcnt = (mcnt + 1) % 8;
  endtask

  task automatic set_counter(input int n);
    do_init_counter();
    repeat (n) do_count();
  endtask

  task automatic do_init_w();
    initW1 = 1; initW2 = 1; initB = 1; tick(); initW1 = 0; initW2 = 0; initB = 0;
    mw1 = 0; mw2 = 0; mb = 0; mep = 0;
  endtask

  task automatic do_ld(input int a, input bit l1, input bit l2, input bit lb);
    int s;
    s = tsign(mt[mcnt]);
    alpha = 8'(a); ldW1 = l1; ldW2 = l2; ldB = lb;
    tick();
    ldW1 = 0; ldW2 = 0; ldB = 0;
    if (l1) mw1 = sat16(mw1 + a * s * mx1[mcnt]);
    if (l2) mw2 = sat16(mw2 + a * s * mx2[mcnt]);
    if (lb) mb = sat16(mb + a * s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; ready = 0; alpha = 0; wr_addr = 0; wr_x1 = 0; wr_x2 = 0; wr_t = 0;
    x1_test = 0; x2_test = 0;
    idle();
    model_reset();
    repeat (2) tick();
    rst = 1;
    tick();
    vectors++; if (w1 !== 16'sd0 || w2 !== 16'sd0 || b !== 16'sd0) begin
      miscompares++; $display("FAIL reset_weights: got w1=%0d w2=%0d b=%0d, want 0 0 0", w1, w2, b);
    end
    vectors++; if (flag !== 1'b0 || epochs !== 8'd0 || cout !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got flag=%b epochs=%0d cout=%b, want 0 0 0", flag, epochs, cout);
    end
    vectors++; if (y_test !== 1'b0 || y_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_test: got y_test=%b y_valid=%b, want 0 0", y_test, y_valid);
    end
    vectors++; if (update !== model_update()) begin
      miscompares++; $display("FAIL reset_update: got %b, want %b", update, model_update());
    end
  endtask

  task automatic test_first_update();
    ready = 1;
    do_init_w();
    write_sample(0, 2, 3, 1'b0);
    do_init_counter();
    vectors++; if (update !== 1'b1) begin
      miscompares++; $display("FAIL first_update_pre: got %b, want 1", update);
    end
    do_ld(1, 1, 1, 1);
    vectors++; if (w1 !== 16'(mw1) || w2 !== 16'(mw2) || b !== 16'(mb)) begin
      miscompares++; $display("FAIL first_update_w: got %0d %0d %0d, want %0d %0d %0d", w1, w2, b, mw1, mw2, mb);
    end
    vectors++; if (update !== 1'b0) begin
      miscompares++; $display("FAIL first_update_post: got %b, want 0", update);
    end
  endtask

  task automatic test_counter();
    do_init_counter();
    for (int i = 0; i < 8; i++) begin
      do_count();
      vectors++; if (cout !== (mcnt == 7)) begin
        miscompares++; $display("FAIL counter_step%0d: got cout=%b, want %b", i, cout, mcnt == 7);
      end
    end
    set_counter(3);
    initCounter = 1; enableCount = 1; tick(); initCounter = 0; enableCount = 0;
    mcnt = 0;
    for (int i = 0; i < 7; i++) begin
      do_count();
      vectors++; if (cout !== (mcnt == 7)) begin
        miscompares++; $display("FAIL counter_init_wins%0d: got cout=%b, want %b", i, cout, mcnt == 7);
      end
    end
  endtask

  task automatic test_saturation();
    write_sample(1, 127, -128, 1'b1);
    write_sample(2, 127, 0, 1'b0);
    set_counter(1);
    do_init_w();
    for (int i = 0; i < 2; i++) begin
      do_ld(255, 1, 1, 0);
      vectors++; if (w1 !== 16'(mw1) || w2 !== 16'(mw2)) begin
        miscompares++; $display("FAIL sat_pos%0d: got w1=%0d w2=%0d, want %0d %0d", i, w1, w2, mw1, mw2);
      end
    end
    do_count();
    for (int i = 0; i < 3; i++) begin
      do_ld(255, 1, 0, 1);
      vectors++; if (w1 !== 16'(mw1) || b !== 16'(mb)) begin
        miscompares++; $display("FAIL sat_neg%0d: got w1=%0d b=%0d, want %0d %0d", i, w1, b, mw1, mb);
      end
    end
    vectors++; if (w1 !== -16'sd32768) begin
      miscompares++; $display("FAIL sat_floor: got %0d, want -32768", w1);
    end
    initW1 = 1; ldW1 = 1; alpha = 8'd10; tick(); initW1 = 0; ldW1 = 0;
    mw1 = 0; mep = 0;
    vectors++; if (w1 !== 16'sd0) begin
      miscompares++; $display("FAIL init_beats_ld: got %0d, want 0", w1);
    end
  endtask

  task automatic test_flag_epochs();
    setFlag = 1; tick(); setFlag = 0; mflag = 1;
    vectors++; if (flag !== mflag) begin
      miscompares++; $display("FAIL flag_set: got %b, want 1", flag);
    end
    initFlag = 1; setFlag = 1; tick(); initFlag = 0; setFlag = 0;
    mflag = 0; mep++;
    vectors++; if (flag !== mflag || epochs !== 8'(mep)) begin
      miscompares++; $display("FAIL flag_init_wins: got flag=%b epochs=%0d, want 0 %0d", flag, epochs, mep);
    end
    for (int i = 0; i < 300; i++) begin
      initFlag = 1; tick(); initFlag = 0;
      if (mep < 255) mep++;
    end
    vectors++; if (epochs !== 8'(mep) || epochs !== 8'd255) begin
      miscompares++; $display("FAIL epochs_sat: got %0d, want 255", epochs);
    end
    initW1 = 1; tick(); initW1 = 0; mw1 = 0; mep = 0;
    vectors++; if (epochs !== 8'd0) begin
      miscompares++; $display("FAIL epochs_clear: got %0d, want 0", epochs);
    end
  endtask

  task automatic test_classify();
    do_init_w();
    write_sample(3, 1, -1, 1'b1);
    set_counter(3);
    do_ld(1, 1, 1, 0);
    vectors++; if (w1 !== 16'sd1 || w2 !== -16'sd1 || b !== 16'sd0) begin
      miscompares++; $display("FAIL classify_setup: got %0d %0d %0d, want 1 -1 0", w1, w2, b);
    end
    x1_test = 8'sd5; x2_test = 8'sd5; enableTest = 1; tick(); enableTest = 0;
    vectors++; if (y_test !== model_classify(5, 5) || y_valid !== 1'b1) begin
      miscompares++; $display("FAIL classify_55: got y=%b v=%b, want %b 1", y_test, y_valid, model_classify(5, 5));
    end
    x1_test = 8'sd0; x2_test = 8'sd1;
    tick();
    vectors++; if (y_test !== 1'b1 || y_valid !== 1'b0) begin
      miscompares++; $display("FAIL classify_hold: got y=%b v=%b, want 1 0", y_test, y_valid);
    end
    enableTest = 1; tick(); enableTest = 0;
    vectors++; if (y_test !== model_classify(0, 1) || y_valid !== 1'b1) begin
      miscompares++; $display("FAIL classify_01: got y=%b v=%b, want %b 1", y_test, y_valid, model_classify(0, 1));
    end
  endtask

  task automatic test_ready_gating();
    // Counter is at 3 holding (1,-1,+1): correctly classified.
    ready = 0;
    write_sample(3, 1, -1, 1'b0);
    vectors++; if (update !== model_update()) begin
      miscompares++; $display("FAIL ready_low_write: got update=%b, want %b", update, model_update());
    end
    ready = 1;
    write_sample(3, 1, -1, 1'b0);
    vectors++; if (update !== model_update()) begin
      miscompares++; $display("FAIL ready_high_write: got update=%b, want %b", update, model_update());
    end
  endtask

  task automatic test_random_training();
    int a;
    int xa, xb;
    ready = 1;
    do_init_w();
    for (int i = 0; i < 8; i++) begin
      write_sample(i, $signed(8'($urandom_range(255, 0))), $signed(8'($urandom_range(255, 0))),
                   1'($urandom_range(1, 0)));
    end
    do_init_counter();
    for (int e = 0; e < 4; e++) begin
      initFlag = 1; tick(); initFlag = 0;
      mflag = 0; if (mep < 255) mep++;
      for (int s = 0; s < 8; s++) begin
        vectors++; if (update !== model_update() || cout !== (mcnt == 7)) begin
          miscompares++; $display("FAIL rand_update e%0d s%0d: got upd=%b cout=%b, want %b %b",
                                  e, s, update, cout, model_update(), mcnt == 7);
        end
        if (model_update()) begin
          a = int'($urandom_range(255, 1));
          setFlag = 1; do_ld(a, 1, 1, 1); setFlag = 0; mflag = 1;
          vectors++; if (w1 !== 16'(mw1) || w2 !== 16'(mw2) || b !== 16'(mb) || flag !== mflag) begin
            miscompares++; $display("FAIL rand_ld e%0d s%0d: got %0d %0d %0d f=%b, want %0d %0d %0d f=%b",
                                    e, s, w1, w2, b, flag, mw1, mw2, mb, mflag);
          end
        end
        do_count();
      end
      vectors++; if (epochs !== 8'(mep) || flag !== mflag) begin
        miscompares++; $display("FAIL rand_epoch%0d: got ep=%0d f=%b, want %0d %b", e, epochs, flag, mep, mflag);
      end
    end
    for (int i = 0; i < 10; i++) begin
      xa = $signed(8'($urandom_range(255, 0)));
      xb = $signed(8'($urandom_range(255, 0)));
      x1_test = 8'(xa); x2_test = 8'(xb);
      enableTest = 1; tick(); enableTest = 0;
      vectors++; if (y_test !== model_classify(xa, xb) || y_valid !== 1'b1) begin
        miscompares++; $display("FAIL rand_test (%0d,%0d): got y=%b v=%b, want %b 1",
                                xa, xb, y_test, y_valid, model_classify(xa, xb));
      end
    end
  endtask

  task automatic test_async_reset();
    set_counter(7);
    setFlag = 1; tick(); setFlag = 0; mflag = 1;
    do_init_w();
    write_sample(7, 40, -20, 1'b1);
    do_ld(3, 1, 1, 1);
    vectors++; if (cout !== 1'b1 || flag !== 1'b1 || w1 !== 16'(mw1) || b !== 16'(mb)) begin
      miscompares++; $display("FAIL pre_reset: got cout=%b f=%b w1=%0d b=%0d, want 1 1 %0d %0d",
                              cout, flag, w1, b, mw1, mb);
    end
    #2;
    rst = 0;
    model_reset();
    #1;
    vectors++; if (w1 !== 16'sd0 || w2 !== 16'sd0 || b !== 16'sd0) begin
      miscompares++; $display("FAIL async_weights: got %0d %0d %0d, want 0 0 0", w1, w2, b);
    end
    vectors++; if (flag !== 1'b0 || cout !== 1'b0 || epochs !== 8'd0) begin
      miscompares++; $display("FAIL async_ctrl: got f=%b cout=%b ep=%0d, want 0 0 0", flag, cout, epochs);
    end
    vectors++; if (update !== model_update()) begin
      miscompares++; $display("FAIL async_mem_clear: got update=%b, want %b", update, model_update());
    end
    tick();
    rst = 1;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_update();
    test_counter();
    test_saturation();
    test_flag_epochs();
    test_classify();
    test_ready_gating();
    test_random_training();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
